// File: rtl/fc_argmax.sv
// Argmax over the 10 signed FC2 scores held in SRAM f: three word reads, a running
// signed maximum, then a registered class index/score with a one-cycle done pulse.
module fc_argmax #(
    parameter int NUM_CLASS              = 10,
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int ADDR_WIDTH             = 2
) (
    input  logic                                         clk,
    input  logic                                         srst,
    input  logic                                         fc2_done,
    input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_f,
    output logic [ADDR_WIDTH-1:0]                        sram_raddr_f,
    output logic                                         busy,
    output logic                                         argmax_done,
    output logic                                         result_valid,
    output logic [3:0]                                   class_out,
    output logic [DATA_WIDTH-1:0]                        max_score
);

    localparam int IDX_W = 4;
    localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, FIN} state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic                           r_busy;
    logic                           r_argmax_done;
    logic                           r_result_valid;
    logic [IDX_W-1:0]               r_class_out;
    logic signed [DATA_WIDTH-1:0]   r_max_score;
    logic signed [DATA_WIDTH-1:0]   r_run_max;
    logic [IDX_W-1:0]               r_run_idx;

    logic [ADDR_WIDTH-1:0]          w_raddr;
    logic [IDX_W-1:0]               w_base;
    logic signed [DATA_WIDTH-1:0]   w_byte;
    logic signed [DATA_WIDTH-1:0]   w_best_val;
    logic [IDX_W-1:0]               w_best_idx;

    // NOTE: every always_comb output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_raddr      = '0;
        w_base       = '0;
        case (r_state)
            IDLE: if (fc2_done) w_next_state = RD0;
            RD0:  w_next_state = RD1;
            RD1: begin
                w_raddr      = ADDR_WIDTH'(1);
                w_next_state = RD2;
            end
            RD2: begin
                w_raddr      = ADDR_WIDTH'(2);
                w_base       = IDX_W'(4);
                w_next_state = FIN;
            end
            FIN: begin
                w_raddr      = ADDR_WIDTH'(2);
                w_base       = IDX_W'(8);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Byte 0 sits in the top byte; a strict '>' scan in index order keeps the lowest
    // index on ties, and padding slots past NUM_CLASS never take part.
    always_comb begin
        w_best_val = r_run_max;
        w_best_idx = r_run_idx;
        w_byte     = '0;
        for (int b = 0; b < DATA_NUM_PER_SRAM_ADDR; b++) begin
            w_byte = sram_rdata_f[DATA_WIDTH*(DATA_NUM_PER_SRAM_ADDR-b)-1 -: DATA_WIDTH];
            if ((int'(w_base) + b < NUM_CLASS) && (w_byte > w_best_val)) begin
                w_best_val = w_byte;
                w_best_idx = w_base + IDX_W'(b);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_argmax_done  <= 1'b0;
            r_result_valid <= 1'b0;
            r_class_out    <= '0;
            r_max_score    <= '0;
            r_run_max      <= SCORE_MIN;
            r_run_idx      <= '0;
        end else begin
            r_state       <= w_next_state;
            r_busy        <= (r_state == RD0) || (r_state == RD1) || (r_state == RD2);
            r_argmax_done <= 1'b0;
            case (r_state)
                IDLE: if (fc2_done) begin
                    r_result_valid <= 1'b0;
                    r_run_max      <= SCORE_MIN;
                    r_run_idx      <= '0;
                end
                RD1, RD2: begin
                    r_run_max <= w_best_val;
                    r_run_idx <= w_best_idx;
                end
                FIN: begin
                    r_class_out    <= w_best_idx;
                    r_max_score    <= w_best_val;
                    r_result_valid <= 1'b1;
                    r_argmax_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sram_raddr_f = w_raddr;
    assign busy         = r_busy;
    assign argmax_done  = r_argmax_done;
    assign result_valid = r_result_valid;
    assign class_out    = r_class_out;
    assign max_score    = r_max_score;

endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: a one-cycle-latency SRAM model, directed score sets, and a
// scoreboard queue drained by a monitor on every argmax_done pulse.
module tb_fc_argmax;

    logic        clk;
    logic        srst;
    logic        fc2_done;
    logic [31:0] sram_rdata_f;
    logic [1:0]  sram_raddr_f;
    logic        busy;
    logic        argmax_done;
    logic        result_valid;
    logic [3:0]  class_out;
    logic [7:0]  max_score;

    typedef struct {
        logic [3:0] cls;
        logic [7:0] score;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:3];
    int          total;
    int          bad;
    int          done_cnt;

    fc_argmax dut (
        .clk          (clk),
        .srst         (srst),
        .fc2_done     (fc2_done),
        .sram_rdata_f (sram_rdata_f),
        .sram_raddr_f (sram_raddr_f),
        .busy         (busy),
        .argmax_done  (argmax_done),
        .result_valid (result_valid),
        .class_out    (class_out),
        .max_score    (max_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (argmax_done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got pulse expected none");
            end else begin
                e = sb_q.pop_front();
                check("class_out", 32'(class_out), 32'(e.cls));
                check("max_score", 32'(max_score), 32'(e.score));
                check("result_valid_at_done", 32'(result_valid), 32'd1);
            end
        end
    end

    task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[3] = 32'hDEAD_BEEF;
    endtask

    // Entered and left #1 after a rising edge; start is sampled on the first edge.
    task automatic run_search(input logic [3:0] cls, input logic [7:0] sc, input string tag);
        sb_q.push_back('{cls, sc});
        fc2_done = 1'b1;
        @(posedge clk); #1; fc2_done = 1'b0;
        check({tag, ".raddr_k0"}, 32'(sram_raddr_f), 32'd0);
        check({tag, ".busy_k0"},  32'(busy),         32'd0);
        check({tag, ".rv_k0"},    32'(result_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".raddr_k1"}, 32'(sram_raddr_f), 32'd1);
        check({tag, ".busy_k1"},  32'(busy),         32'd1);
        @(posedge clk); #1;
        check({tag, ".raddr_k2"}, 32'(sram_raddr_f), 32'd2);
        check({tag, ".busy_k2"},  32'(busy),         32'd1);
        @(posedge clk); #1;
        check({tag, ".raddr_k3"}, 32'(sram_raddr_f), 32'd2);
        check({tag, ".busy_k3"},  32'(busy),         32'd1);
        check({tag, ".done_k3"},  32'(argmax_done),  32'd0);
        @(posedge clk); #1;
        check({tag, ".done_k4"},  32'(argmax_done),  32'd1);
        check({tag, ".rv_k4"},    32'(result_valid), 32'd1);
        check({tag, ".busy_k4"},  32'(busy),         32'd0);
        @(posedge clk); #1;
        check({tag, ".done_k5"},  32'(argmax_done),  32'd0);
        check({tag, ".rv_k5"},    32'(result_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cycles;
        int done_before;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        srst     = 1'b1;
        fc2_done = 1'b0;
        load(32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        check("rst.raddr", 32'(sram_raddr_f), 32'd0);
        check("rst.busy",  32'(busy),         32'd0);
        check("rst.done",  32'(argmax_done),  32'd0);
        check("rst.rv",    32'(result_valid), 32'd0);
        check("rst.class", 32'(class_out),    32'd0);
        check("rst.score", 32'(max_score),    32'd0);
        @(posedge clk); #1;

        // Peak 0x7F at index 7 (addr 1 byte 3).
        load(32'h0102_0304, 32'h0506_107F, 32'h0809_0000);
        run_search(4'd7, 8'h7F, "t1");

        // Signed scores; the winner sits at addr 2 byte 1.
        load(32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F1_F0F0);
        run_search(4'd9, 8'hF1, "t2");

        // Padding slots hold the largest value but must be ignored; ties go low.
        load(32'h0505_0505, 32'h0505_0505, 32'h0505_7F7F);
        run_search(4'd0, 8'h05, "t3");

        // fc2_done held over three edges: only the first starts a search.
        load(32'h0102_0304, 32'h0506_107F, 32'h0809_0000);
        sb_q.push_back('{4'd7, 8'h7F});
        done_before = done_cnt;
        busy_cycles = 0;
        fc2_done = 1'b1;
        @(posedge clk); #1; busy_cycles += int'(busy);
        @(posedge clk); #1; busy_cycles += int'(busy);
        @(posedge clk); #1; busy_cycles += int'(busy);
        fc2_done = 1'b0;
        @(posedge clk); #1; busy_cycles += int'(busy);
        @(posedge clk); #1; busy_cycles += int'(busy);
        check("t4.done_k4", 32'(argmax_done), 32'd1);
        check("t4.busy_cycles", 32'(busy_cycles), 32'd3);
        // Back-to-back start while argmax_done is high.
        load(32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F1_F0F0);
        sb_q.push_back('{4'd9, 8'hF1});
        fc2_done = 1'b1;
        @(posedge clk); #1; fc2_done = 1'b0;
        check("t4.rv_cleared",   32'(result_valid), 32'd0);
        check("t4.class_held",   32'(class_out),    32'd7);
        check("t4.score_held",   32'(max_score),    32'h7F);
        check("t4.done_dropped", 32'(argmax_done),  32'd0);
        repeat (3) @(posedge clk);
        #1 check("t4.b2b_done_early", 32'(argmax_done), 32'd0);
        @(posedge clk); #1;
        check("t4.b2b_done", 32'(argmax_done), 32'd1);
        @(posedge clk); #1;
        check("t4.done_pulses", 32'(done_cnt - done_before), 32'd2);

        // srst in RD2 together with fc2_done: abandon, reset values, no pulse.
        load(32'h0102_0304, 32'h0506_107F, 32'h0809_0000);
        done_before = done_cnt;
        fc2_done = 1'b1;
        @(posedge clk); #1; fc2_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        srst     = 1'b1;
        fc2_done = 1'b1;
        @(posedge clk); #1;
        srst     = 1'b0;
        fc2_done = 1'b0;
        check("t5.raddr", 32'(sram_raddr_f), 32'd0);
        check("t5.busy",  32'(busy),         32'd0);
        check("t5.done",  32'(argmax_done),  32'd0);
        check("t5.rv",    32'(result_valid), 32'd0);
        check("t5.class", 32'(class_out),    32'd0);
        check("t5.score", 32'(max_score),    32'd0);
        repeat (6) @(posedge clk);
        #1 check("t5.idle_busy", 32'(busy), 32'd0);
        check("t5.no_pulse", 32'(done_cnt - done_before), 32'd0);
        run_search(4'd7, 8'h7F, "t5r");

        // Every score at the minimum: nothing beats the initial running max.
        load(32'h8080_8080, 32'h8080_8080, 32'h8080_8080);
        run_search(4'd0, 8'h80, "t6");

        repeat (3) @(posedge clk);
        #1 check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("total_pulses", 32'(done_cnt), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
